hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It sits beside the forwarding logic and drives the enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three hazards: load-use stalls, taken-branch flushes, and LSU back-pressure freezes. It also keeps a memory-wait watchdog and saturating stall and flush performance counters.

## Interface
- TIMEOUT, default 255: number of consecutive freeze cycles after which mem_timeout_o is set.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- ID_Rs1_addr_i  in  5  rs1 of instruction in ID
- ID_Rs2_addr_i  in  5  rs2 of instruction in ID
- ID_rs1_used_i  in  1  ID instruction reads rs1
- ID_rs2_used_i  in  1  ID instruction reads rs2
- ID_EX_Rd_i  in  5  rd of instruction in EX
- ID_EX_mem_rd_i  in  1  EX instruction is a load
- br_taken_i  in  1  branch/jump in EX resolved taken (redirect)
- EX_MEM_mem_req_i  in  1  MEM-stage instruction is accessing memory
- mem_ready_i  in  1  LSU completes the access this cycle
- PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o, MEM_WB_en_o  out  1 each  stage register load enables
- IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o  out  1 each  load a bubble (NOP, all write-enables 0)
- mem_timeout_o  out  1  sticky watchdog flag
- stall_cnt_o  out  CNT_W  stall cycles, saturating
- flush_cnt_o  out  CNT_W  branch-flush cycles, saturating

## Operation
- Control outputs are combinational (Mealy) from the registered state and current inputs. Counters, watchdog and state are registered.
- Internal conditions:
  - freeze = EX_MEM_mem_req_i && !mem_ready_i.
  - lu = ID_EX_mem_rd_i && ID_EX_Rd_i!=0 && ((ID_rs1_used_i && ID_EX_Rd_i==ID_Rs1_addr_i) || (ID_rs2_used_i && ID_EX_Rd_i==ID_Rs2_addr_i)).
- Priority is freeze > br_taken_i > lu > normal.
- freeze:
  - All *_en_o are 0 except MEM_WB_en_o=1 with MEM_WB_flush_o=1, so a bubble enters WB.
  - IF_ID_flush_o and ID_EX_flush_o are 0.
  - br_taken_i is ignored that cycle. It persists because EX is held.
- br_taken_i (no freeze):
  - All enables are 1, IF_ID_flush_o=1 and ID_EX_flush_o=1.
  - The wrong-path ID instruction is discarded, so lu is irrelevant.
- lu (no freeze, no branch):
  - PC_en_o=0, IF_ID_en_o=0, ID_EX_en_o=1 with ID_EX_flush_o=1, EX_MEM_en_o=1, MEM_WB_en_o=1.
  - This gives exactly one bubble. Next cycle the load is in MEM, lu drops, and forwarding covers it.
- Normal: all enables 1, all flushes 0.
- FSM has two states:
  - RUN: freeze moves it to WAIT; otherwise it stays in RUN.
  - WAIT: freeze keeps it in WAIT; !freeze moves it to RUN. The release cycle is a normal, branch or lu cycle per the priority above.
- Watchdog: wait_cnt (width ceil(log2(TIMEOUT+1))).
  - Increments every freeze cycle, saturating at TIMEOUT.
  - Clears to 0 on any non-freeze cycle.
  - When the incremented value equals TIMEOUT, mem_timeout_o is set next edge and held until rst_i.
- stall_cnt_o increments on every freeze or lu cycle.
- flush_cnt_o increments on every branch-flush cycle.
- Both counters saturate at 2^CNT_W-1.

## Timing
- Reset (rst_i high at an edge):
  - State→RUN; wait_cnt, stall_cnt_o, flush_cnt_o and mem_timeout_o→0.
  - While rst_i is high, all *_en_o=0 and all *_flush_o=1, regardless of inputs.
- Reset mid-WAIT: the next cycle after rst_i deasserts is RUN with counters 0. Outputs follow the current inputs.
- Control latency is 0 cycles (same-cycle response). Counter and flag update latency is 1 cycle.
- mem_ready_i asserted in the same cycle as EX_MEM_mem_req_i gives no freeze and no state change.
- EX_MEM_mem_req_i dropping while in WAIT counts as a release.
- At a simultaneous freeze, branch and lu: only the freeze counts (stall_cnt_o +1, flush_cnt_o unchanged).

## Test plan
- Load-use: load x5 in EX, ID reads x5 via rs2 with ID_rs2_used_i=1 → one cycle with PC_en_o=0, IF_ID_en_o=0, ID_EX_flush_o=1; stall_cnt_o=1; next cycle normal. Repeat with rd=x0 or ID_rs2_used_i=0 → no stall.
- Branch over load-use: lu and br_taken_i together → IF_ID_flush_o=ID_EX_flush_o=1, PC_en_o=1; flush_cnt_o=1, stall_cnt_o=0.
- LSU wait: mem_req=1, mem_ready=0 for 3 cycles, then ready → 3 freeze cycles (MEM_WB_flush_o=1, other enables 0), state WAIT→RUN, stall_cnt_o=3, 4th cycle normal.
- Watchdog: TIMEOUT=4, freeze for 4 cycles → mem_timeout_o=1 from cycle 5, stays 1 after release; 3-cycle freeze → stays 0.
- Saturation: CNT_W=3, 9 consecutive lu cycles → stall_cnt_o holds 7.
- Reset in WAIT: assert rst_i on freeze cycle 2 → all enables 0, all flushes 1, counters 0; after deassert with mem_ready=1 → normal operation.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//
// Drives the stage-register load enables and bubble (flush) controls of
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three hazards, listed
// here highest priority first:
//   freeze : LSU back-pressure (MEM access pending, not ready)
//   branch : taken branch/jump resolved in EX
//   lu     : load-use dependency between the EX load and the ID instruction
// It also keeps a memory-wait watchdog and saturating perf counters.
//
// Ports:
//   clk_i, rst_i                 core clock, synchronous active-high reset
//   ID_Rs1/Rs2_addr_i, ID_rs*_used_i   source operands of the ID instruction
//   ID_EX_Rd_i, ID_EX_mem_rd_i   destination / load flag of the EX instruction
//   br_taken_i                   EX redirect
//   EX_MEM_mem_req_i, mem_ready_i  MEM-stage access handshake with the LSU
//   *_en_o, *_flush_o            stage controls (combinational, same cycle)
//   mem_timeout_o                sticky watchdog flag
//   stall_cnt_o, flush_cnt_o     saturating stall / branch-flush cycle counts
//
// States:
//   S_RUN  | pipeline advancing (normal, branch or load-use cycles)
//   S_WAIT | frozen on an outstanding LSU access
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_Rs1_addr_i,
    input  logic [4:0]       ID_Rs2_addr_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic [4:0]       ID_EX_Rd_i,
    input  logic             ID_EX_mem_rd_i,
    input  logic             br_taken_i,
    input  logic             EX_MEM_mem_req_i,
    input  logic             mem_ready_i,
    output logic             PC_en_o,
    output logic             IF_ID_en_o,
    output logic             ID_EX_en_o,
    output logic             EX_MEM_en_o,
    output logic             MEM_WB_en_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             MEM_WB_flush_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;

    logic freeze;
    logic lu;
    logic branch_cyc;
    logic stall_cyc;

    always_comb begin
        freeze = EX_MEM_mem_req_i && !mem_ready_i;
        lu     = ID_EX_mem_rd_i && (ID_EX_Rd_i != 5'd0) &&
                 ((ID_rs1_used_i && (ID_EX_Rd_i == ID_Rs1_addr_i)) ||
                  (ID_rs2_used_i && (ID_EX_Rd_i == ID_Rs2_addr_i)));
        // A branch redirect discards the ID instruction, so lu only stalls
        // when no branch is taken; a freeze masks both.
        branch_cyc = !freeze && br_taken_i;
        stall_cyc  = freeze || (!br_taken_i && lu);
    end

    // Next state and stage controls.
    always_comb begin
        state_next     = state;
        PC_en_o        = 1'b1;
        IF_ID_en_o     = 1'b1;
        ID_EX_en_o     = 1'b1;
        EX_MEM_en_o    = 1'b1;
        MEM_WB_en_o    = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        MEM_WB_flush_o = 1'b0;

        unique case (state)
            S_RUN:   if (freeze)  state_next = S_WAIT;
            S_WAIT:  if (!freeze) state_next = S_RUN;
            default: state_next = S_RUN;
        endcase

        if (rst_i) begin
            PC_en_o        = 1'b0;
            IF_ID_en_o     = 1'b0;
            ID_EX_en_o     = 1'b0;
            EX_MEM_en_o    = 1'b0;
            MEM_WB_en_o    = 1'b0;
            IF_ID_flush_o  = 1'b1;
            ID_EX_flush_o  = 1'b1;
            MEM_WB_flush_o = 1'b1;
        end else if (freeze) begin
            // Hold everything up to MEM; WB still loads, but with a bubble.
            PC_en_o        = 1'b0;
            IF_ID_en_o     = 1'b0;
            ID_EX_en_o     = 1'b0;
            EX_MEM_en_o    = 1'b0;
            MEM_WB_flush_o = 1'b1;
        end else if (br_taken_i) begin
            IF_ID_flush_o  = 1'b1;
            ID_EX_flush_o  = 1'b1;
        end else if (lu) begin
            // Hold PC and ID, inject one bubble into EX.
            PC_en_o        = 1'b0;
            IF_ID_en_o     = 1'b0;
            ID_EX_flush_o  = 1'b1;
        end
    end

    always_comb begin
        wait_inc = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_RUN;
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            state <= state_next;

            if (freeze) begin
                wait_cnt <= wait_inc;
                if (wait_inc == WAIT_MAX) mem_timeout_o <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (stall_cyc && (stall_cnt_o != CNT_MAX))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (branch_cyc && (flush_cnt_o != CNT_MAX))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues one stimulus per cycle
// and pushes the expected response computed by a behavioural model; a
// separate monitor pops and compares every cycle.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, br, req, rdy;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_fl, idex_fl, memwb_fl, to;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs1_addr_i(rs1), .ID_Rs2_addr_i(rs2),
        .ID_rs1_used_i(u1), .ID_rs2_used_i(u2),
        .ID_EX_Rd_i(rd), .ID_EX_mem_rd_i(ld),
        .br_taken_i(br), .EX_MEM_mem_req_i(req), .mem_ready_i(rdy),
        .PC_en_o(pc_en), .IF_ID_en_o(ifid_en), .ID_EX_en_o(idex_en),
        .EX_MEM_en_o(exmem_en), .MEM_WB_en_o(memwb_en),
        .IF_ID_flush_o(ifid_fl), .ID_EX_flush_o(idex_fl), .MEM_WB_flush_o(memwb_fl),
        .mem_timeout_o(to), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    typedef struct packed {
        logic [7:0] ctrl;   // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB en, IF_ID,ID_EX,MEM_WB flush}
        int         stall;
        int         flush;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (what the registered outputs show this cycle).
    int   m_stall = 0, m_flush = 0, m_wait = 0;
    logic m_to = 1'b0;

    task automatic step(input logic s_rst, input logic [4:0] s_rs1, input logic [4:0] s_rs2,
                        input logic s_u1, input logic s_u2, input logic [4:0] s_rd,
                        input logic s_ld, input logic s_br, input logic s_req, input logic s_rdy);
        bit   fz, hz;
        exp_t e;
        @(negedge clk);
        rst = s_rst; rs1 = s_rs1; rs2 = s_rs2; u1 = s_u1; u2 = s_u2;
        rd = s_rd; ld = s_ld; br = s_br; req = s_req; rdy = s_rdy;

        fz = s_req && !s_rdy;
        hz = s_ld && (s_rd != 0) && ((s_u1 && s_rd == s_rs1) || (s_u2 && s_rd == s_rs2));
        if (s_rst)     e.ctrl = 8'b00000_111;
        else if (fz)   e.ctrl = 8'b00001_001;
        else if (s_br) e.ctrl = 8'b11111_110;
        else if (hz)   e.ctrl = 8'b00111_010;
        else           e.ctrl = 8'b11111_000;
        e.stall = m_stall; e.flush = m_flush; e.to = m_to;
        exp_q.push_back(e);

        if (s_rst) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
        end else begin
            if (fz) begin
                m_wait = (m_wait < TIMEOUT) ? m_wait + 1 : TIMEOUT;
                if (m_wait == TIMEOUT) m_to = 1'b1;
            end else begin
                m_wait = 0;
            end
            if ((fz || (!s_br && hz)) && m_stall < CMAX) m_stall++;
            if (!fz && s_br && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic nop();
        step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic freeze_cyc();
        step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_cyc();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one comparison set per presented cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl};
                checks += 4;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got %b expected %b", $time, act, e.ctrl);
                end
                if (^stall_cnt === 1'bx || int'(stall_cnt) != e.stall) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, e.stall);
                end
                if (^flush_cnt === 1'bx || int'(flush_cnt) != e.flush) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t got %0d expected %0d", $time, flush_cnt, e.flush);
                end
                if (to !== e.to) begin
                    errors++;
                    $display("FAIL mem_timeout t=%0t got %b expected %b", $time, to, e.to);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0;
        ld = 0; br = 0; req = 0; rdy = 0;
        @(posedge clk);
        reset_cyc();
        reset_cyc();

        // Load-use via rs2, then cases that must not stall.
        step(0, 5'd3, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0);
        nop();
        step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
        step(0, 5'd3, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0);
        step(0, 5'd7, 5'd1, 1, 0, 5'd7, 1, 0, 0, 0);

        // Branch over load-use.
        reset_cyc();
        step(0, 5'd3, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0);
        nop();

        // LSU wait: three freezes, branch pending, then release with branch.
        reset_cyc();
        repeat (3) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1, 1);
        nop();

        // Watchdog: 3-cycle freeze must not trip, 4-cycle freeze must.
        reset_cyc();
        repeat (3) freeze_cyc();
        nop();
        nop();
        repeat (4) freeze_cyc();
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0);
        nop();
        nop();

        // Stall counter saturation.
        reset_cyc();
        repeat (9) step(0, 5'd9, 5'd4, 1, 0, 5'd9, 1, 0, 0, 0);
        nop();

        // Reset in WAIT, release with mem_ready.
        reset_cyc();
        freeze_cyc();
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1);
        nop();

        // Randomized traffic with small register indices to provoke hits.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), ($urandom_range(0, 2) != 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
